// File: rtl/mem_resp_tracker_pkg.sv
// -----------------------------------------------------------------------------
// mem_resp_pkg
// Shared types for the memory-stage response tracker:
//   slot_state_e : lifecycle of one tracker slot (FREE / WAIT / DATA / KILL)
//   SZ_B..SZ_D   : request access-size codes (byte, half, word, dword)
// -----------------------------------------------------------------------------
package mem_resp_pkg;

  typedef enum logic [1:0] {
    ST_FREE = 2'd0,  // slot unused
    ST_WAIT = 2'd1,  // request issued, response pending
    ST_DATA = 2'd2,  // aligned result held, waiting for writeback
    ST_KILL = 2'd3   // request flushed, response still owed by the cache
  } slot_state_e;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

endpackage

// File: rtl/mem_resp_tracker_load_align.sv
// -----------------------------------------------------------------------------
// load_align
// Combinational load-result aligner: selects the addressed lane of the raw
// cache word and zero- or sign-extends it to DATA_W.
// Ports:
//   i_rdata  : raw cache read data
//   i_size   : access size code (SZ_B/SZ_H/SZ_W/SZ_D)
//   i_sign   : 1 = sign-extend, 0 = zero-extend
//   i_off    : byte offset of the access inside the data word
//   o_result : aligned, extended result
// -----------------------------------------------------------------------------
module load_align
  import mem_resp_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int OFF_W  = $clog2(DATA_W / 8)
) (
  input  logic [DATA_W-1:0] i_rdata,
  input  logic [1:0]        i_size,
  input  logic              i_sign,
  input  logic [OFF_W-1:0]  i_off,
  output logic [DATA_W-1:0] o_result
);

  logic [OFF_W-1:0]  w_lane_mask;
  logic [OFF_W-1:0]  w_aoff;
  logic [DATA_W-1:0] w_shifted;
  logic signed [7:0]  w_byte_s;
  logic signed [15:0] w_half_s;
  logic signed [31:0] w_word_s;
  logic [DATA_W-1:0] w_word_ext;

  // Clearing the low offset bits turns the byte offset into the lane base for
  // the access size; with DATA_W=32 a word mask clears every bit.
  always_comb begin
    w_lane_mask = '0;
    case (i_size)
      SZ_B: w_lane_mask = '1;
      SZ_H: w_lane_mask = ~OFF_W'(1);
      SZ_W: w_lane_mask = ~OFF_W'(3);
      SZ_D: w_lane_mask = '0;
    endcase
  end

  assign w_aoff    = i_off & w_lane_mask;
  assign w_shifted = i_rdata >> {w_aoff, 3'b000};

  assign w_byte_s = w_shifted[7:0];
  assign w_half_s = w_shifted[15:0];
  assign w_word_s = w_shifted[31:0];

  assign w_word_ext = i_sign ? DATA_W'(w_word_s) : DATA_W'(w_shifted[31:0]);

  always_comb begin
    o_result = w_shifted;
    case (i_size)
      SZ_B: o_result = i_sign ? DATA_W'(w_byte_s) : DATA_W'(w_shifted[7:0]);
      SZ_H: o_result = i_sign ? DATA_W'(w_half_s) : DATA_W'(w_shifted[15:0]);
      SZ_W: o_result = w_word_ext;
      // A dword request on a 32-bit datapath is a plain word access.
      SZ_D: o_result = (DATA_W == 64) ? w_shifted : w_word_ext;
    endcase
  end

endmodule

// File: rtl/mem_resp_tracker.sv
// -----------------------------------------------------------------------------
// mem_resp_tracker
// Keeps up to DEPTH data-cache requests in flight, matches in-order cache
// responses to them, stores each load result already aligned, and hands
// results to writeback in order. Flushed requests become KILL slots whose late
// responses are absorbed silently.
// Ports:
//   clk, resetn                 : clock, synchronous active-low reset
//   req_valid/req_ready         : request issue handshake
//   req_size/sign/off/meta      : per-request access info and sideband
//   flush                       : pipeline flush, highest priority
//   data_ok/data_rdata          : in-order cache response
//   out_valid/out_ready         : writeback handshake
//   out_data/out_meta           : aligned result and sideband at the head
//   inflight                    : occupied slot count
//   err_unexp                   : sticky, response arrived with nothing owed
// -----------------------------------------------------------------------------
module mem_resp_tracker
  import mem_resp_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 4,
  parameter  int META_W = 8,
  localparam int OFF_W  = $clog2(DATA_W / 8),
  localparam int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_size,
  input  logic              req_sign,
  input  logic [OFF_W-1:0]  req_off,
  input  logic [META_W-1:0] req_meta,
  input  logic              flush,
  input  logic              data_ok,
  input  logic [DATA_W-1:0] data_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [META_W-1:0] out_meta,
  output logic [PTR_W:0]    inflight,
  output logic              err_unexp
);

  slot_state_e       r_state [DEPTH];
  logic [1:0]        r_size  [DEPTH];
  logic              r_sign  [DEPTH];
  logic [OFF_W-1:0]  r_off   [DEPTH];
  logic [META_W-1:0] r_meta  [DEPTH];
  logic [DATA_W-1:0] r_data  [DEPTH];

  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [PTR_W-1:0]  r_resp;
  logic [PTR_W:0]    r_inflight;
  logic              r_err;

  slot_state_e       w_resp_st;
  slot_state_e       w_head_st;
  logic              w_enq;
  logic              w_deq;
  logic              w_rsp_wait;
  logic              w_rsp_kill;
  logic              w_rsp_unexp;
  logic [PTR_W-1:0]  w_resp_nxt;
  slot_state_e       w_flush_st [DEPTH];
  logic [PTR_W:0]    w_kill_cnt;
  logic [DATA_W-1:0] w_aligned;

  assign w_resp_st = r_state[r_resp];
  assign w_head_st = r_state[r_head];

  // Admission uses the registered count, so a dequeue in a full cycle does not
  // open a slot until the next cycle.
  assign req_ready = (r_inflight != (PTR_W+1)'(DEPTH)) && !flush;
  assign out_valid = (w_head_st == ST_DATA) && !flush;

  assign w_enq       = req_valid && req_ready;
  assign w_deq       = out_valid && out_ready;
  assign w_rsp_wait  = data_ok && (w_resp_st == ST_WAIT);
  assign w_rsp_kill  = data_ok && (w_resp_st == ST_KILL);
  assign w_rsp_unexp = data_ok && !w_rsp_wait && !w_rsp_kill;
  assign w_resp_nxt  = r_resp + PTR_W'(w_rsp_wait || w_rsp_kill);

  // Slot states after a flush: the same-cycle response retires its slot first,
  // then every outstanding request still owed a response becomes KILL and
  // everything else (including held results) is dropped.
  always_comb begin
    w_kill_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_flush_st[i] = ST_FREE;
      if (((r_state[i] == ST_WAIT) || (r_state[i] == ST_KILL)) &&
          !(data_ok && (PTR_W'(i) == r_resp))) begin
        w_flush_st[i] = ST_KILL;
        w_kill_cnt    = w_kill_cnt + (PTR_W+1)'(1);
      end
    end
  end

  load_align #(.DATA_W(DATA_W)) u_align (
    .i_rdata  (data_rdata),
    .i_size   (r_size[r_resp]),
    .i_sign   (r_sign[r_resp]),
    .i_off    (r_off[r_resp]),
    .o_result (w_aligned)
  );

  // Capture stage: slot control state and pointers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) r_state[i] <= ST_FREE;
      r_head     <= '0;
      r_tail     <= '0;
      r_resp     <= '0;
      r_inflight <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_rsp_unexp) r_err <= 1'b1;
      if (flush) begin
        for (int i = 0; i < DEPTH; i++) r_state[i] <= w_flush_st[i];
        r_resp     <= w_resp_nxt;
        r_head     <= w_resp_nxt;
        r_inflight <= w_kill_cnt;
      end else begin
        // Enqueue, response and dequeue always touch distinct slots
        // (FREE, WAIT/KILL and DATA respectively).
        if (w_enq) begin
          r_state[r_tail] <= ST_WAIT;
          r_tail          <= r_tail + PTR_W'(1);
        end
        if (w_rsp_wait) r_state[r_resp] <= ST_DATA;
        if (w_rsp_kill) r_state[r_resp] <= ST_FREE;
        r_resp <= w_resp_nxt;
        if (w_deq) r_state[r_head] <= ST_FREE;
        // KILL slots are always oldest, so a kill-free and a dequeue never
        // coincide; either one advances the head.
        if (w_deq || w_rsp_kill) r_head <= r_head + PTR_W'(1);
        r_inflight <= r_inflight + (PTR_W+1)'(w_enq)
                                 - (PTR_W+1)'(w_deq)
                                 - (PTR_W+1)'(w_rsp_kill);
      end
    end
  end

  // Capture stage: per-slot payload
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_size[r_tail] <= req_size;
      r_sign[r_tail] <= req_sign;
      r_off[r_tail]  <= req_off;
      r_meta[r_tail] <= req_meta;
    end
    if (w_rsp_wait) r_data[r_resp] <= w_aligned;
  end

  assign out_data  = r_data[r_head];
  assign out_meta  = r_meta[r_head];
  assign inflight  = r_inflight;
  assign err_unexp = r_err;

endmodule

// File: tb/tb_mem_resp_tracker.sv
// -----------------------------------------------------------------------------
// tb_mem_resp_tracker
// Directed bench for mem_resp_tracker (DATA_W=32, DEPTH=4) plus a DATA_W=64
// instance for the dword/word-lane cases. A reference model keeps queues of
// pending requests and expected results; results are pushed when a response
// is driven and popped when the writeback handshake takes them.
// -----------------------------------------------------------------------------
module tb_mem_resp_tracker;
  import mem_resp_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic        req_valid, req_ready, req_sign, flush, data_ok;
  logic [1:0]  req_size, req_off;
  logic [7:0]  req_meta, out_meta;
  logic [31:0] data_rdata, out_data;
  logic        out_valid, out_ready, err_unexp;
  logic [2:0]  inflight;

  logic        req_valid64, req_ready64, req_sign64, flush64, data_ok64;
  logic [1:0]  req_size64;
  logic [2:0]  req_off64, inflight64;
  logic [7:0]  req_meta64, out_meta64;
  logic [63:0] data_rdata64, out_data64;
  logic        out_valid64, out_ready64, err_unexp64;

  mem_resp_tracker #(.DATA_W(32), .DEPTH(4), .META_W(8)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_size(req_size),
    .req_sign(req_sign), .req_off(req_off), .req_meta(req_meta),
    .flush(flush), .data_ok(data_ok), .data_rdata(data_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_meta(out_meta), .inflight(inflight), .err_unexp(err_unexp)
  );

  mem_resp_tracker #(.DATA_W(64), .DEPTH(4), .META_W(8)) dut64 (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid64), .req_ready(req_ready64), .req_size(req_size64),
    .req_sign(req_sign64), .req_off(req_off64), .req_meta(req_meta64),
    .flush(flush64), .data_ok(data_ok64), .data_rdata(data_rdata64),
    .out_valid(out_valid64), .out_ready(out_ready64), .out_data(out_data64),
    .out_meta(out_meta64), .inflight(inflight64), .err_unexp(err_unexp64)
  );

  typedef struct packed {
    logic [1:0] sz;
    logic       sg;
    logic [1:0] off;
    logic [7:0] meta;
  } pend_t;

  pend_t       pend_q [$];
  logic [39:0] exp_q  [$];
  int          m_kills;
  logic        m_err;
  int          n_cmp  = 0;
  int          n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int m_infl();
    return pend_q.size() + exp_q.size() + m_kills;
  endfunction

  function automatic logic [31:0] model_align(input logic [31:0] d, input logic [1:0] sz,
                                              input logic sg, input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    case (sz)
      2'd0: begin
        b = d[off*8 +: 8];
        return sg ? {{24{b[7]}}, b} : {24'h0, b};
      end
      2'd1: begin
        h = off[1] ? d[31:16] : d[15:0];
        return sg ? {{16{h[15]}}, h} : {16'h0, h};
      end
      default: return d;
    endcase
  endfunction

  // Drive one cycle of stimulus, check outputs against the model before the
  // edge, advance the model, then move to 1 ns after the edge.
  task automatic step(input logic rv, input logic [1:0] sz, input logic sg,
                      input logic [1:0] off, input logic [7:0] meta,
                      input logic dok, input logic [31:0] rd,
                      input logic ordy, input logic fl);
    logic  e_ready, e_outv;
    pend_t p;
    req_valid = rv;  req_size = sz;  req_sign = sg;  req_off = off;
    req_meta = meta; data_ok = dok;  data_rdata = rd; out_ready = ordy;
    flush = fl;
    #1;
    e_ready = (m_infl() != 4) && !fl;
    e_outv  = (exp_q.size() > 0) && !fl;
    check("req_ready", 64'(req_ready), 64'(e_ready));
    check("out_valid", 64'(out_valid), 64'(e_outv));
    check("inflight",  64'(inflight),  64'(m_infl()));
    check("err_unexp", 64'(err_unexp), 64'(m_err));
    if (e_outv) begin
      check("out_data", 64'(out_data), 64'(exp_q[0][39:8]));
      check("out_meta", 64'(out_meta), 64'(exp_q[0][7:0]));
    end
    if (e_outv && ordy) void'(exp_q.pop_front());
    if (dok) begin
      if (m_kills > 0) m_kills--;
      else if (pend_q.size() > 0) begin
        p = pend_q.pop_front();
        exp_q.push_back({model_align(rd, p.sz, p.sg, p.off), p.meta});
      end else m_err = 1'b1;
    end
    if (rv && e_ready) pend_q.push_back('{sz, sg, off, meta});
    if (fl) begin
      m_kills += pend_q.size();
      pend_q.delete();
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 2'd0, 1'b0, 2'd0, 8'h00, 1'b0, 32'h0, ordy, 1'b0);
  endtask

  task automatic load(input logic [1:0] sz, input logic sg, input logic [1:0] off,
                      input logic [7:0] meta);
    step(1'b1, sz, sg, off, meta, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic resp(input logic [31:0] rd, input logic ordy);
    step(1'b0, 2'd0, 1'b0, 2'd0, 8'h00, 1'b1, rd, ordy, 1'b0);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    req_valid = 0; req_size = 0; req_sign = 0; req_off = 0; req_meta = 0;
    flush = 0; data_ok = 0; data_rdata = 0; out_ready = 0;
    pend_q.delete(); exp_q.delete(); m_kills = 0; m_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  initial begin
    req_valid64 = 0; req_size64 = 0; req_sign64 = 0; req_off64 = 0;
    req_meta64 = 0; flush64 = 0; data_ok64 = 0; data_rdata64 = 0; out_ready64 = 0;

    // Reset values, then fill all four slots and drain in order.
    do_reset();
    idle(1'b0);
    for (int i = 0; i < 4; i++) load(SZ_W, 1'b0, 2'd0, 8'h10 + 8'(i));
    for (int i = 0; i < 4; i++) resp($urandom, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Sign-extended byte and zero-extended half.
    load(SZ_B, 1'b1, 2'd3, 8'hA1);
    resp(32'h8012_3456, 1'b0);
    check("byte_sign_const", 64'(out_data), 64'h0000_0000_FFFF_FF80);
    idle(1'b1);
    load(SZ_H, 1'b0, 2'd2, 8'hA2);
    resp(32'hBEEF_0000, 1'b0);
    check("half_zero_const", 64'(out_data), 64'h0000_0000_0000_BEEF);
    idle(1'b1);

    // Back-to-back mixed sizes with overlapping issue and response.
    for (int i = 0; i < 8; i++)
      step(1'b1, 2'($urandom_range(0, 3)), 1'($urandom), 2'($urandom),
           8'h40 + 8'(i), (i > 0), $urandom, 1'b1, 1'b0);
    resp($urandom, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Flush with one result stalled at the head and two responses owed.
    for (int i = 0; i < 3; i++) load(SZ_W, 1'b0, 2'd0, 8'h20 + 8'(i));
    resp(32'h1111_1111, 1'b0);
    idle(1'b0);
    step(1'b0, 2'd0, 1'b0, 2'd0, 8'h00, 1'b0, 32'h0, 1'b1, 1'b1);
    check("flush_inflight", 64'(inflight), 64'd2);
    resp(32'h2222_2222, 1'b1);
    resp(32'h3333_3333, 1'b1);
    idle(1'b1);

    // Flush coincident with a response and a new request.
    load(SZ_W, 1'b0, 2'd0, 8'h30);
    load(SZ_W, 1'b0, 2'd0, 8'h31);
    step(1'b1, SZ_W, 1'b0, 2'd0, 8'h32, 1'b1, 32'h4444_4444, 1'b1, 1'b1);
    check("flush_resp_req_inflight", 64'(inflight), 64'd1);
    resp(32'h5555_5555, 1'b1);
    idle(1'b1);

    // Full queue: dequeue, capture and a refused request in one cycle.
    for (int i = 0; i < 4; i++) load(SZ_W, 1'b0, 2'd0, 8'h50 + 8'(i));
    resp(32'h6666_6666, 1'b0);
    step(1'b1, SZ_W, 1'b0, 2'd0, 8'h5F, 1'b1, 32'h7777_7777, 1'b1, 1'b0);
    check("full_deq_capture_inflight", 64'(inflight), 64'd3);
    resp(32'h8888_8888, 1'b1);
    resp(32'h9999_9999, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Unexpected response is sticky until reset.
    resp(32'hDEAD_BEEF, 1'b1);
    idle(1'b1);
    idle(1'b1);
    check("err_sticky", 64'(err_unexp), 64'd1);

    // Reset mid-operation; the late response then counts as unexpected.
    load(SZ_W, 1'b0, 2'd0, 8'h60);
    load(SZ_W, 1'b0, 2'd0, 8'h61);
    do_reset();
    idle(1'b1);
    resp(32'hCAFE_0000, 1'b1);
    idle(1'b1);
    do_reset();
    idle(1'b1);

    // DATA_W=64: dword passes through, word on upper lane sign-extends.
    req_valid64 = 1; req_size64 = SZ_D; req_off64 = 3'd0; req_meta64 = 8'h5A;
    @(posedge clk); #1;
    req_valid64 = 0; data_ok64 = 1; data_rdata64 = 64'h0123_4567_89AB_CDEF;
    @(posedge clk); #1;
    data_ok64 = 0;
    check("d64_valid", 64'(out_valid64), 64'd1);
    check("d64_dword", out_data64, 64'h0123_4567_89AB_CDEF);
    check("d64_meta",  64'(out_meta64), 64'h5A);
    out_ready64 = 1;
    @(posedge clk); #1;
    out_ready64 = 0;
    check("d64_inflight", 64'(inflight64), 64'd0);
    req_valid64 = 1; req_size64 = SZ_W; req_sign64 = 1; req_off64 = 3'd4; req_meta64 = 8'h5B;
    @(posedge clk); #1;
    req_valid64 = 0; data_ok64 = 1; data_rdata64 = 64'h8000_0001_1234_5678;
    @(posedge clk); #1;
    data_ok64 = 0;
    check("d64_word_hi_sign", out_data64, 64'hFFFF_FFFF_8000_0001);
    check("d64_err", 64'(err_unexp64), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
